// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter and its source FIFOs.
// Packet layouts here fix the bit order of the FIFO payloads.
package cdb_arbiter_pkg;

    localparam int DATA_W  = 32;
    localparam int ENTRY_W = 5;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } cdb_src_e;

    localparam logic CDB_SRC_ALU = 1'b0;
    localparam logic CDB_SRC_LSB = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0]  result;
        logic [DATA_W-1:0]  pc;
        logic [ENTRY_W-1:0] entry;
    } alu_pkt_t;

    typedef struct packed {
        logic [DATA_W-1:0]  result;
        logic [ENTRY_W-1:0] entry;
    } lsb_pkt_t;

    localparam int ALU_PKT_W = $bits(alu_pkt_t);
    localparam int LSB_PKT_W = $bits(lsb_pkt_t);

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result FIFO: circular buffer with registered occupancy count.
// Push into a full FIFO and pop from an empty one are ignored here as a safety net.
module cdb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == FULL_CNT);
    assign empty  = (count_r == {(PTR_W+1){1'b0}});
    assign head   = mem_r[rd_ptr_r];
    assign push_s = push && !full && !flush;
    assign pop_s  = pop && !empty && !flush;

    // Pointer and occupancy bookkeeping; flush returns to the empty state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage; contents are only meaningful between wr_ptr and rd_ptr.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter between the ALU and load/store result FIFOs, driving the
// registered common data bus that feeds ROB, RS and LSB wakeup.
import cdb_arbiter_pkg::*;

module cdb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                roll_back,
    input  logic                alu_valid,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [DATA_W-1:0]   alu_pc,
    input  logic [ENTRY_W-1:0]  alu_entry,
    output logic                alu_full,
    input  logic                lsb_valid,
    input  logic [DATA_W-1:0]   lsb_result,
    input  logic [ENTRY_W-1:0]  lsb_entry,
    output logic                lsb_full,
    output logic                cdb_valid,
    output logic [DATA_W-1:0]   cdb_result,
    output logic [DATA_W-1:0]   cdb_pc,
    output logic [ENTRY_W-1:0]  cdb_entry,
    output logic                cdb_src,
    output logic                overflow
);

    logic     active_s;
    logic     flush_s;
    logic     alu_push_s;
    logic     lsb_push_s;
    logic     alu_pop_s;
    logic     lsb_pop_s;
    logic     alu_empty_s;
    logic     lsb_empty_s;
    alu_pkt_t alu_wdata_s;
    lsb_pkt_t lsb_wdata_s;
    alu_pkt_t alu_head_s;
    lsb_pkt_t lsb_head_s;
    logic     grant_valid_s;
    cdb_src_e grant_src_s;
    cdb_src_e last_grant_r;

    assign active_s    = rdy_in && !roll_back;
    assign flush_s     = rdy_in && roll_back;
    // Full flags come from the registered count, so a same-cycle pop never frees a slot.
    assign alu_push_s  = active_s && alu_valid && !alu_full;
    assign lsb_push_s  = active_s && lsb_valid && !lsb_full;
    assign alu_pop_s   = active_s && grant_valid_s && (grant_src_s == SRC_ALU);
    assign lsb_pop_s   = active_s && grant_valid_s && (grant_src_s == SRC_LSB);
    assign alu_wdata_s = '{result: alu_result, pc: alu_pc, entry: alu_entry};
    assign lsb_wdata_s = '{result: lsb_result, entry: lsb_entry};

    cdb_fifo #(
        .WIDTH (ALU_PKT_W),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_alu_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (alu_push_s),
        .pop   (alu_pop_s),
        .flush (flush_s),
        .wdata (alu_wdata_s),
        .head  (alu_head_s),
        .full  (alu_full),
        .empty (alu_empty_s)
    );

    cdb_fifo #(
        .WIDTH (LSB_PKT_W),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_lsb_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (lsb_push_s),
        .pop   (lsb_pop_s),
        .flush (flush_s),
        .wdata (lsb_wdata_s),
        .head  (lsb_head_s),
        .full  (lsb_full),
        .empty (lsb_empty_s)
    );

    // Grant selection: alternate when both sources wait, otherwise serve whoever has data.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_src_s   = SRC_ALU;
        if (!alu_empty_s && !lsb_empty_s) begin
            grant_valid_s = 1'b1;
            grant_src_s   = (last_grant_r == SRC_ALU) ? SRC_LSB : SRC_ALU;
        end else if (!alu_empty_s) begin
            grant_valid_s = 1'b1;
            grant_src_s   = SRC_ALU;
        end else if (!lsb_empty_s) begin
            grant_valid_s = 1'b1;
            grant_src_s   = SRC_LSB;
        end else begin
            grant_valid_s = 1'b0;
            grant_src_s   = SRC_ALU;
        end
    end

    // Broadcast registers and round-robin history; everything holds while rdy_in is low.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cdb_valid    <= 1'b0;
            cdb_result   <= {DATA_W{1'b0}};
            cdb_pc       <= {DATA_W{1'b0}};
            cdb_entry    <= {ENTRY_W{1'b0}};
            cdb_src      <= CDB_SRC_ALU;
            last_grant_r <= SRC_LSB;
        end else if (rdy_in) begin
            if (roll_back) begin
                cdb_valid    <= 1'b0;
                last_grant_r <= SRC_LSB;
            end else if (grant_valid_s) begin
                cdb_valid    <= 1'b1;
                last_grant_r <= grant_src_s;
                case (grant_src_s)
                    SRC_ALU: begin
                        cdb_result <= alu_head_s.result;
                        cdb_pc     <= alu_head_s.pc;
                        cdb_entry  <= alu_head_s.entry;
                        cdb_src    <= CDB_SRC_ALU;
                    end
                    SRC_LSB: begin
                        cdb_result <= lsb_head_s.result;
                        cdb_pc     <= {DATA_W{1'b0}};
                        cdb_entry  <= lsb_head_s.entry;
                        cdb_src    <= CDB_SRC_LSB;
                    end
                    default: begin
                        cdb_valid <= 1'b0;
                    end
                endcase
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

    // Sticky flag for any push that hit a full FIFO; survives roll_back.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            overflow <= 1'b0;
        end else if (active_s && ((alu_valid && alu_full) || (lsb_valid && lsb_full))) begin
            overflow <= 1'b1;
        end
    end

endmodule
